// File: rtl/interrupt_controller.sv
// interrupt_controller
//
// Request-capture and dispatch stage feeding the priority encoder path.
// Rising edges on the request lines are latched into a pending register.
// The highest-index pending, unmasked line is offered to a consumer via a
// valid/ack handshake. It is then held in service until end-of-interrupt.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous, active-high reset
//   irq_in     in   N  raw level request lines; a rising edge is a new request
//   mask       in   N  1 = line not eligible for dispatch (still latched as pending)
//   ack        in   1  consumer accepts irq_id; honoured only while irq_valid is high
//   eoi        in   1  consumer finished servicing; honoured only while busy is high
//   irq_valid  out  1  irq_id valid, awaiting ack
//   irq_id     out  M  index of the dispatched request
//   pending    out  N  latched, not-yet-acknowledged requests
//   busy       out  1  request acknowledged and in service
//
// All outputs come straight from flops.
module interrupt_controller #(
   parameter int unsigned N = 8,
   parameter int unsigned M = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] irq_in,
   input  logic [N-1:0] mask,
   input  logic         ack,
   input  logic         eoi,
   output logic         irq_valid,
   output logic [M-1:0] irq_id,
   output logic [N-1:0] pending,
   output logic         busy
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StReq     = 2'd1,
      StService = 2'd2
   } state_e;

   state_e       state_q, state_d;
   logic [N-1:0] irq_q, irq_d;
   logic [N-1:0] pending_q, pending_d;
   logic [M-1:0] irq_id_q, irq_id_d;
   logic         irq_valid_q, irq_valid_d;
   logic         busy_q, busy_d;

   logic [N-1:0] rise;
   logic [N-1:0] elig;
   logic [N-1:0] clr;
   logic [M-1:0] enc;
   logic         ack_take;

   // Edge detect against the previous sample of irq_in.
   assign rise = irq_in & ~irq_q;
   assign elig = pending_q & ~mask;

   // Priority encoder: the ascending scan lets the highest set index win.
   // The value is don't-care when elig is zero.
   always_comb begin
      enc = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (elig[i]) begin
            enc = M'(i);
         end
      end
   end

   assign ack_take = (state_q == StReq) && ack;

   // One-hot clear of the acknowledged line. The clear is built by compare
   // rather than by indexing, so that an N that is not a power of two never
   // indexes past the vector.
   always_comb begin
      clr = '0;
      for (int unsigned i = 0; i < N; i++) begin
         clr[i] = ack_take && (irq_id_q == M'(i));
      end
   end

   // Set wins over clear. A re-edge on a bit that is already pending merges
   // into that bit and does not accumulate.
   assign pending_d = (pending_q & ~clr) | rise;
   assign irq_d     = irq_in;

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      irq_id_d    = irq_id_q;
      irq_valid_d = irq_valid_q;
      busy_d      = busy_q;

      unique case (state_q)
         StIdle: begin
            irq_valid_d = 1'b0;
            busy_d      = 1'b0;
            if (elig != '0) begin
               irq_id_d    = enc;
               irq_valid_d = 1'b1;
               state_d     = StReq;
            end
         end
         StReq: begin
            // irq_id is frozen. New or newly unmasked lines do not preempt,
            // and masking the selected line does not withdraw it.
            irq_valid_d = 1'b1;
            busy_d      = 1'b0;
            if (ack) begin
               irq_valid_d = 1'b0;
               busy_d      = 1'b1;
               state_d     = StService;
            end
         end
         StService: begin
            irq_valid_d = 1'b0;
            busy_d      = 1'b1;
            if (eoi) begin
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: begin
            irq_valid_d = 1'b0;
            busy_d      = 1'b0;
            state_d     = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         irq_q       <= '0;
         pending_q   <= '0;
         irq_id_q    <= '0;
         irq_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         irq_q       <= irq_d;
         pending_q   <= pending_d;
         irq_id_q    <= irq_id_d;
         irq_valid_q <= irq_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign irq_valid = irq_valid_q;
   assign irq_id    = irq_id_q;
   assign pending   = pending_q;
   assign busy      = busy_q;

endmodule
